regfile_write_arbiter: RTL and testbench

Shares the register file's single write port (we, 4-bit address, 16-bit data) among three requesters: ALU writeback (req 0), memory-load return (req 1) and pixel-unit R12 update (req 2). It accepts at most one write per cycle using round-robin arbitration with valid/ready handshakes. The winning write is registered and driven to the register file one cycle later. It also exports a busy mask of registers with writes in flight, which the hazard logic uses to stall readers.

---
 rtl/regfile_write_arbiter_pkg.sv | 19 +
 rtl/regfile_write_arbiter_rr_arbiter.sv | 32 +++
 rtl/regfile_write_arbiter.sv | 91 +++++++++
 tb/tb_regfile_write_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared register-file constants and write-request payload type.
package regfile_pkg;

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned AW       = 4;
  localparam int unsigned DW       = 16;

  localparam int unsigned REG_PU   = 12;
  localparam int unsigned REG_SP   = 13;
  localparam int unsigned REG_PC   = 14;
  localparam int unsigned SP_RESET = 640;

  typedef struct packed {
    logic          valid;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_req_t;

endpackage

// File: rtl/regfile_write_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned N = 3,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic        found;
  int unsigned j;

  // Walk the requesters starting at ptr, wrapping modulo N.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port among N_REQ requesters, round-robin,
// with a one-cycle registered output stage and a busy mask for hazard stalls.
module regfile_write_arbiter #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned AW    = 4,
  parameter int unsigned DW    = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hold,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ-1:0][AW-1:0]   req_addr,
  input  logic [N_REQ-1:0][DW-1:0]   req_data,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       rf_we,
  output logic [AW-1:0]              rf_addr,
  output logic [DW-1:0]              rf_data,
  output logic [(2**AW)-1:0]         busy_mask
);

  import regfile_pkg::*;

  localparam int unsigned IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IW-1:0]    ptr;
  logic [IW-1:0]    ptr_nxt;
  logic [IW-1:0]    win_idx;
  logic [N_REQ-1:0] arb_req;
  logic [N_REQ-1:0] arb_gnt;
  logic             xfer;
  wr_req_t          win;

  // Hold and reset suppress all grants; data never feeds the grant path.
  assign arb_req   = (rst || hold) ? '0 : req_valid;
  assign req_ready = arb_gnt;
  assign xfer      = |arb_gnt;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req (arb_req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (win_idx)
  );

  // Select the winning write payload.
  always_comb begin
    win       = '0;
    win.valid = xfer;
    win.addr  = req_addr[win_idx];
    win.data  = req_data[win_idx];
  end

  // Pointer advances past the winner; unchanged when nothing transfers.
  always_comb begin
    ptr_nxt = ptr;
    if (xfer) begin
      ptr_nxt = (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr <= '0;
    else     ptr <= ptr_nxt;
  end

  // Output stage: address/data only reload on a transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_data <= '0;
    end else begin
      rf_we <= win.valid;
      if (win.valid) begin
        rf_addr <= win.addr;
        rf_data <= win.data;
      end
    end
  end

  // Registers targeted by any pending request or by the write in flight.
  always_comb begin
    busy_mask = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (req_valid[i]) busy_mask[req_addr[i]] = 1'b1;
    end
    if (rf_we) busy_mask[rf_addr] = 1'b1;
  end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: behavioural model compared every negedge,
// plus directed scenarios with literal expectations.
module tb_regfile_write_arbiter;

  logic             clk = 1'b0;
  logic             rst;
  logic             hold;
  logic [2:0]       req_valid;
  logic [2:0][3:0]  req_addr;
  logic [2:0][15:0] req_data;
  logic [2:0]       req_ready;
  logic             rf_we;
  logic [3:0]       rf_addr;
  logic [15:0]      rf_data;
  logic [15:0]      busy_mask;

  int n_chk = 0;
  int n_err = 0;

  logic [2:0]  oneshot;
  logic [2:0]  g_last;
  logic        stab_en;
  logic [15:0] tb_rf [16];

  // Model state
  int          m_ptr;
  logic        m_we;
  logic [3:0]  m_addr;
  logic [15:0] m_data;

  always #5 clk = ~clk;

  regfile_write_arbiter #(.N_REQ(3), .AW(4), .DW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .hold      (hold),
    .req_valid (req_valid),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rf_we     (rf_we),
    .rf_addr   (rf_addr),
    .rf_data   (rf_data),
    .busy_mask (busy_mask)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // First valid requester searching p, p+1, ... mod 3; -1 if none.
  function automatic int pick(input logic [2:0] v, input int p);
    for (int k = 0; k < 3; k++) begin
      if (v[(p + k) % 3]) return (p + k) % 3;
    end
    return -1;
  endfunction

  // Register file driven by the DUT write port; SP has its own reset value.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < 16; r++) tb_rf[r] <= (r == 13) ? 16'd640 : 16'd0;
    end else if (rf_we) begin
      tb_rf[rf_addr] <= rf_data;
    end
  end

  // Behavioural model of pointer and output stage.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ptr <= 0; m_we <= 1'b0; m_addr <= '0; m_data <= '0;
    end else if (!hold && pick(req_valid, m_ptr) >= 0) begin
      m_we   <= 1'b1;
      m_addr <= req_addr[pick(req_valid, m_ptr)];
      m_data <= req_data[pick(req_valid, m_ptr)];
      m_ptr  <= (pick(req_valid, m_ptr) + 1) % 3;
    end else begin
      m_we <= 1'b0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [2:0]  e_rdy;
    logic [15:0] e_busy;
    g_last = req_ready;
    e_rdy  = 3'b000;
    if (!rst && !hold && pick(req_valid, m_ptr) >= 0) e_rdy[pick(req_valid, m_ptr)] = 1'b1;
    e_busy = 16'h0000;
    for (int i = 0; i < 3; i++) if (req_valid[i]) e_busy[req_addr[i]] = 1'b1;
    if (m_we) e_busy[m_addr] = 1'b1;
    chk("model_ready", 32'(req_ready), 32'(e_rdy));
    chk("model_we",    32'(rf_we),     32'(m_we));
    chk("model_addr",  32'(rf_addr),   32'(m_addr));
    chk("model_data",  32'(rf_data),   32'(m_data));
    chk("model_busy",  32'(busy_mask), 32'(e_busy));
  end

  // Requesters keep valid/addr/data stable until their transfer.
  for (genvar gi = 0; gi < 3; gi++) begin : g_stab
    a_stab: assert property (@(posedge clk) disable iff (rst || !stab_en)
      (req_valid[gi] && !req_ready[gi]) |=>
      (req_valid[gi] && $stable(req_addr[gi]) && $stable(req_data[gi])))
      else begin n_err++; $display("FAIL stable_req%0d", gi); end
  end

  // Advance one cycle; one-shot requesters drop valid after their grant.
  task automatic nxt();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) if (oneshot[i] && g_last[i]) req_valid[i] = 1'b0;
  endtask

  initial begin
    rst = 1'b1; hold = 1'b0; stab_en = 1'b1; oneshot = 3'b000;
    req_valid = 3'b001; req_addr = '0; req_data = '0;
    req_addr[0] = 4'd5;

    // Reset: no grant, busy reflects inputs only
    @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_busy",  32'(busy_mask), 32'h0020);
    chk("rst_we",    32'(rf_we),     32'h0);
    chk("rst_addr",  32'(rf_addr),   32'h0);
    chk("rst_data",  32'(rf_data),   32'h0);
    @(posedge clk); #1;
    req_valid = 3'b000;
    rst = 1'b0;

    // All three continuously valid: grants 0,1,2,0,1,2
    req_addr[0] = 4'd1; req_data[0] = 16'h000A;
    req_addr[1] = 4'd2; req_data[1] = 16'h000B;
    req_addr[2] = 4'd12; req_data[2] = 16'h000C;
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      logic [3:0] ea [3];
      ea[0] = 4'd1; ea[1] = 4'd2; ea[2] = 4'd12;
      @(negedge clk);
      chk("rr_ready", 32'(req_ready), 32'(1 << (k % 3)));
      if (k > 0) begin
        chk("rr_we",   32'(rf_we),   32'h1);
        chk("rr_addr", 32'(rf_addr), 32'(ea[(k - 1) % 3]));
      end
      nxt();
    end
    stab_en = 1'b0;
    req_valid = 3'b000;
    @(negedge clk);
    chk("rr_last_addr", 32'(rf_addr), 32'd12);
    nxt();
    stab_en = 1'b1;

    // Single requester
    req_addr[0] = 4'd3; req_data[0] = 16'h1234;
    oneshot = 3'b111; req_valid = 3'b001;
    @(negedge clk);
    chk("single_ready", 32'(req_ready), 32'h1);
    chk("single_busy0", 32'(busy_mask), 32'h0008);
    nxt();
    @(negedge clk);
    chk("single_we",    32'(rf_we),     32'h1);
    chk("single_addr",  32'(rf_addr),   32'h3);
    chk("single_data",  32'(rf_data),   32'h1234);
    chk("single_busy1", 32'(busy_mask), 32'h0008);
    nxt();

    // Reset one cycle after req 2 transfers
    req_addr[2] = 4'd12; req_data[2] = 16'h00FF; req_valid = 3'b100;
    @(negedge clk);
    chk("r12_ready", 32'(req_ready), 32'h4);
    nxt();
    chk("r12_we_pre", 32'(rf_we), 32'h1);
    chk("r12_addr_pre", 32'(rf_addr), 32'd12);
    rst = 1'b1;
    #1;
    chk("mrst_we",   32'(rf_we),   32'h0);
    chk("mrst_addr", 32'(rf_addr), 32'h0);
    chk("mrst_data", 32'(rf_data), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_r12", 32'(tb_rf[12]), 32'h0);
    nxt();

    // Collision on R13 with ptr at 0
    req_addr[0] = 4'd13; req_data[0] = 16'h0111;
    req_addr[1] = 4'd13; req_data[1] = 16'h0222;
    req_valid = 3'b011;
    @(negedge clk);
    chk("col_ready0", 32'(req_ready), 32'h1);
    chk("col_busy",   32'(busy_mask), 32'h2000);
    nxt();
    @(negedge clk);
    chk("col_ready1", 32'(req_ready), 32'h2);
    chk("col_data0",  32'(rf_data),   32'h0111);
    nxt();
    @(negedge clk);
    chk("col_data1", 32'(rf_data), 32'h0222);
    chk("col_addr1", 32'(rf_addr), 32'd13);
    nxt();
    @(negedge clk);
    chk("col_r13", 32'(tb_rf[13]), 32'h0222);
    nxt();

    // Hold for three cycles with req 1 pending
    hold = 1'b1;
    req_addr[1] = 4'd7; req_data[1] = 16'h7777; req_valid = 3'b010;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("hold_ready", 32'(req_ready), 32'h0);
      chk("hold_we",    32'(rf_we),     32'h0);
      nxt();
    end
    hold = 1'b0;
    @(negedge clk);
    chk("unhold_ready", 32'(req_ready), 32'h2);
    nxt();
    @(negedge clk);
    chk("unhold_addr", 32'(rf_addr), 32'd7);
    chk("unhold_data", 32'(rf_data), 32'h7777);
    nxt();

    // Idle for ten cycles; pointer must stay at 2
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("idle_we",   32'(rf_we),     32'h0);
      chk("idle_busy", 32'(busy_mask), 32'h0);
      nxt();
    end
    req_addr[1] = 4'd4; req_data[1] = 16'h4444;
    req_addr[2] = 4'd9; req_data[2] = 16'h9999;
    req_valid = 3'b110;
    @(negedge clk);
    chk("post_idle_ready", 32'(req_ready), 32'h4);
    chk("post_idle_busy",  32'(busy_mask), 32'h0210);
    nxt();
    @(negedge clk);
    chk("post_idle_ready2", 32'(req_ready), 32'h2);
    chk("post_idle_addr",   32'(rf_addr),   32'd9);
    nxt();
    @(negedge clk);
    chk("post_idle_addr2", 32'(rf_addr), 32'd4);
    nxt();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
